// File: rtl/ex_wb_pipe.sv
// Execute + writeback stage: ALU, word-addressed data memory, registered EX/WB result.
// Latency: ALU ops retire 1 cycle after accept, loads/stores MEM_LAT+1 cycles after accept.
// Backpressure: in_ready drops while a memory access is in flight; flush kills work in flight.
//
// Ports: clock/reset_n (async active-low); in_valid/in_ready upstream handshake; flush;
//   decoded controls alu_src, alu_op, mem_read, mem_write, reg_write, wai; operands rd1, rd2,
//   imm, pc; destination rd. Outputs out_valid (one pulse per retired instruction),
//   out_reg_write, out_rd, wb_data, zero, neg.
// Optional: define EX_WB_PERF_CNT_EN to add stall_cycles, a saturating count of cycles
//   with in_valid=1 and in_ready=0.
module ex_wb_pipe #(
    parameter int DATA_W  = 32,
    parameter int RD_W    = 6,
    parameter int MEM_AW  = 6,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              alu_src,
    input  logic [2:0]        alu_op,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic              wai,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] pc,
    input  logic [RD_W-1:0]   rd,
    output logic              out_valid,
    output logic              out_reg_write,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              zero,
`ifdef EX_WB_PERF_CNT_EN
    output logic              neg,
    output logic [31:0]       stall_cycles
`else
    output logic              neg
`endif
);

    localparam int DEPTH = 2 ** MEM_AW;
    // Counter only needs to hold MEM_LAT-1; keep at least one bit for MEM_LAT=1.
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                load_q;
    logic                store_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   wb_q;
    logic [RD_W-1:0]     rd_q;
    logic                reg_write_q;
    logic                zero_q;
    logic                neg_q;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic [DATA_W-1:0]   opb;
    logic [DATA_W-1:0]   alu_res;
    logic                accept;
    logic                is_mem;
    logic                last_mem;
    logic                wr_en;

    always_comb begin
        opb = alu_src ? imm : rd2;
        alu_res = '0;
        case (alu_op)
            3'b000:  alu_res = rd1 + opb;
            3'b001:  alu_res = rd1 - opb;
            3'b010:  alu_res = rd1 & opb;
            3'b011:  alu_res = rd1 | opb;
            3'b100:  alu_res = opb;
            3'b101:  alu_res = rd1 + DATA_W'(1);
            3'b110:  alu_res = '0 - rd1;
            default: alu_res = rd1;
        endcase
    end

    // IDLE and WB both accept, so ALU instructions stream at one per cycle.
    assign in_ready = (state != MEM);
    assign accept   = in_valid & in_ready & ~flush;
    assign is_mem   = mem_read | mem_write;
    assign last_mem = (state == MEM) && (cnt == '0);
    // A flush on the final MEM edge wins over the store.
    assign wr_en    = last_mem & store_q & ~flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            load_q      <= 1'b0;
            store_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wb_q        <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                MEM: begin
                    if (cnt == '0) begin
                        state <= WB;
                        if (load_q) wb_q <= mem[addr_q];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (accept) begin
                        rd_q        <= rd;
                        reg_write_q <= reg_write;
                        load_q      <= mem_read;
                        // Load wins when both are set: the store is dropped.
                        store_q     <= mem_write & ~mem_read;
                        addr_q      <= rd1[MEM_AW-1:0];
                        wdata_q     <= rd2;
                        // Load data overwrites this on the final MEM edge.
                        wb_q        <= wai ? pc : alu_res;
                        if (is_mem) begin
                            state <= MEM;
                            cnt   <= CNT_W'(MEM_LAT - 1);
                        end else begin
                            state  <= WB;
                            zero_q <= (alu_res == '0);
                            neg_q  <= alu_res[DATA_W-1];
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Memory contents survive reset; reset only abandons a pending store via state.
    always_ff @(posedge clock) begin
        if (wr_en) mem[addr_q] <= wdata_q;
    end

    assign out_valid     = (state == WB);
    assign out_reg_write = reg_write_q;
    assign out_rd        = rd_q;
    assign wb_data       = wb_q;
    assign zero          = zero_q;
    assign neg           = neg_q;

`ifdef EX_WB_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (in_valid && !in_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_wb_pipe.sv
// Directed bench for ex_wb_pipe with default parameters (DATA_W=32, MEM_AW=6, MEM_LAT=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Every check goes through check_eq with hand-computed expected values.
module tb_ex_wb_pipe;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        alu_src = 1'b0;
    logic [2:0]  alu_op = 3'b000;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        reg_write = 1'b0;
    logic        wai = 1'b0;
    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;
    logic [31:0] imm = '0;
    logic [31:0] pc = '0;
    logic [5:0]  rd = '0;
    logic        out_valid;
    logic        out_reg_write;
    logic [5:0]  out_rd;
    logic [31:0] wb_data;
    logic        zero;
    logic        neg;
`ifdef EX_WB_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] stall_base;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ex_wb_pipe dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .wai           (wai),
        .rd1           (rd1),
        .rd2           (rd2),
        .imm           (imm),
        .pc            (pc),
        .rd            (rd),
        .out_valid     (out_valid),
        .out_reg_write (out_reg_write),
        .out_rd        (out_rd),
        .wb_data       (wb_data),
        .zero          (zero),
`ifdef EX_WB_PERF_CNT_EN
        .neg           (neg),
        .stall_cycles  (stall_cycles)
`else
        .neg           (neg)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic asrc, input logic [2:0] op, input logic mr, input logic mw,
                         input logic rw, input logic w, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p, input logic [5:0] r);
        in_valid  = 1'b1;
        alu_src   = asrc;
        alu_op    = op;
        mem_read  = mr;
        mem_write = mw;
        reg_write = rw;
        wai       = w;
        rd1       = a;
        rd2       = b;
        imm       = im;
        pc        = p;
        rd        = r;
    endtask

    task automatic idle_in();
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wai       = 1'b0;
    endtask

    // Memory op: accept edge, MEM_LAT cycles with in_ready low, then one out_valid pulse.
    task automatic mem_op(input string tag, input logic mr, input logic mw, input logic w,
                          input logic [31:0] a, input logic [31:0] b, input logic [5:0] r);
        issue(1'b0, 3'b000, mr, mw, 1'b1, w, a, b, 32'h0, 32'h40, r);
        tick();
        idle_in();
        check_eq({tag, "_rdy0"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_vld0"}, 32'(out_valid), 32'd0);
        tick();
        check_eq({tag, "_rdy1"}, 32'(in_ready), 32'd0);
        tick();
        check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_rdy2"}, 32'(in_ready), 32'd1);
    endtask

    logic [31:0] tbl_a  = 32'hF0F0_00FF;
    logic [31:0] tbl_b  = 32'h0FF0_0F0F;
    logic [2:0]  tbl_op [6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};
    logic [31:0] tbl_ex [6] = '{32'h00E0_100E, 32'h00F0_000F, 32'hFFF0_0FFF,
                                32'h0FF0_0F0F, 32'hF0F0_0100, 32'hF0F0_00FF};

    initial begin
        // Reset values
        #12;
        check_eq("rst_vld", 32'(out_valid), 32'd0);
        check_eq("rst_rdy", 32'(in_ready), 32'd1);
        check_eq("rst_wb", wb_data, 32'd0);
        check_eq("rst_flags", {30'd0, zero, neg}, 32'd0);
        check_eq("rst_rd", 32'(out_rd), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        tick();

        // ALU subtract to zero
        issue(1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 32'd7, 32'd7, 32'd0, 32'd0, 6'd3);
        tick();
        idle_in();
        check_eq("sub_vld", 32'(out_valid), 32'd1);
        check_eq("sub_wb", wb_data, 32'd0);
        check_eq("sub_zn", {30'd0, zero, neg}, 32'd2);
        check_eq("sub_rd", 32'(out_rd), 32'd3);
        check_eq("sub_rw", 32'(out_reg_write), 32'd1);
        check_eq("sub_rdy", 32'(in_ready), 32'd1);
        tick();
        check_eq("sub_pulse", 32'(out_valid), 32'd0);

        // Negate using immediate operand select
        issue(1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 32'd9, 32'd5, 32'd0, 6'd4);
        tick();
        idle_in();
        check_eq("neg_wb", wb_data, 32'hFFFF_FFFE);
        check_eq("neg_zn", {30'd0, zero, neg}, 32'd1);

        // Store with address wrap (0x45 -> 5), then load it back; flags hold
        mem_op("st5", 1'b0, 1'b1, 1'b0, 32'h45, 32'h1234, 6'd0);
        check_eq("st5_rw", 32'(out_reg_write), 32'd1);
        tick();
        mem_op("ld5", 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 6'd4);
        check_eq("ld5_wb", wb_data, 32'h1234);
        check_eq("ld5_zn_hold", {30'd0, zero, neg}, 32'd1);
        tick();

        // Back-to-back ALU table, in_valid held high throughout
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, tbl_op[i], 1'b0, 1'b0, 1'b1, 1'b0, tbl_a, tbl_b, 32'd0, 32'd0, 6'(i + 10));
            tick();
            check_eq($sformatf("b2b%0d_vld", i), 32'(out_valid), 32'd1);
            check_eq($sformatf("b2b%0d_wb", i), wb_data, tbl_ex[i]);
            check_eq($sformatf("b2b%0d_rd", i), 32'(out_rd), 32'(i + 10));
            check_eq($sformatf("b2b%0d_rdy", i), 32'(in_ready), 32'd1);
        end
        idle_in();
        tick();
        check_eq("b2b_end", 32'(out_valid), 32'd0);

        // Jump-and-link writes PC; with mem_read the load data wins
        issue(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 32'd1, 32'd1, 32'd0, 32'h40, 6'd63);
        tick();
        idle_in();
        check_eq("jal_wb", wb_data, 32'h40);
        check_eq("jal_rd", 32'(out_rd), 32'd63);
        tick();
        mem_op("jalld", 1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 6'd63);
        check_eq("jalld_wb", wb_data, 32'h1234);
        tick();

        // Load+store together: treated as load, store suppressed
        mem_op("ldst", 1'b1, 1'b1, 1'b0, 32'd5, 32'hFFFF, 6'd2);
        check_eq("ldst_wb", wb_data, 32'h1234);
        tick();
        mem_op("ldst_chk", 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 6'd2);
        check_eq("ldst_mem", wb_data, 32'h1234);
        tick();

        // Flush on first MEM cycle of a store to addr 9
        mem_op("st9", 1'b0, 1'b1, 1'b0, 32'd9, 32'h1111, 6'd0);
        tick();
        issue(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd9, 32'hBEEF, 32'd0, 32'd0, 6'd0);
        tick();
        idle_in();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("fl_rdy", 32'(in_ready), 32'd1);
        check_eq("fl_vld", 32'(out_valid), 32'd0);
        tick();
        check_eq("fl_vld2", 32'(out_valid), 32'd0);
        // Instruction presented with flush is not accepted
        issue(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 6'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_in();
        check_eq("fl_noacc", 32'(out_valid), 32'd0);
        mem_op("ld9", 1'b1, 1'b0, 1'b0, 32'd9, 32'd0, 6'd1);
        check_eq("ld9_wb", wb_data, 32'h1111);
        tick();

        // Flush on the final MEM edge also suppresses the store
        issue(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd9, 32'hBEEF, 32'd0, 32'd0, 6'd0);
        tick();
        idle_in();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("fl2_vld", 32'(out_valid), 32'd0);
        mem_op("ld9b", 1'b1, 1'b0, 1'b0, 32'd9, 32'd0, 6'd1);
        check_eq("ld9b_wb", wb_data, 32'h1111);
        tick();

`ifdef EX_WB_PERF_CNT_EN
        // Two stalled cycles while a store occupies MEM
        stall_base = stall_cycles;
        issue(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd10, 32'h77, 32'd0, 32'd0, 6'd0);
        tick();
        tick();
        tick();
        idle_in();
        check_eq("perf_stall", stall_cycles - stall_base, 32'd2);
        tick();
        check_eq("perf_hold", stall_cycles - stall_base, 32'd2);
        tick();
`endif

        // Reset asserted mid-MEM store: outputs clear, store abandoned
        issue(1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 32'd5, 32'hDEAD, 32'd0, 32'd0, 6'd7);
        tick();
        idle_in();
        reset_n = 1'b0;
        #1;
        check_eq("mrst_vld", 32'(out_valid), 32'd0);
        check_eq("mrst_rdy", 32'(in_ready), 32'd1);
        check_eq("mrst_wb", wb_data, 32'd0);
        check_eq("mrst_rd", 32'(out_rd), 32'd0);
        check_eq("mrst_rw", 32'(out_reg_write), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        mem_op("ld5r", 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 6'd4);
        check_eq("ld5r_wb", wb_data, 32'h1234);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end

endmodule
